inst_fetch_ctrl: RTL and testbench

//  Fetch sequencer for the 16-bit instruction memory of the filter processor.

---
 rtl/inst_fetch_ctrl.sv | 139 +++++++++++++
 tb/tb_inst_fetch_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_ctrl.sv
// rtl/inst_fetch_ctrl.sv - instruction fetch sequencer with 2-entry skid FIFO, redirect, halt and wrap
module inst_fetch_ctrl #(
  parameter int ADDR_W   = 32,
  parameter int INST_W   = 16,
  parameter int PROG_LEN = 4,
  parameter int PC_RESET = 0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [INST_W-1:0] i_mem_data,
  output logic [INST_W-1:0] o_inst,
  output logic [ADDR_W-1:0] o_inst_pc,
  output logic              o_inst_valid,
  input  logic              i_inst_ready,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  input  logic              i_halt,
  output logic              o_halted,
  output logic              o_fault
);

  localparam logic [ADDR_W-1:0] LAST_PC  = ADDR_W'(PROG_LEN - 1);
  localparam logic [ADDR_W-1:0] PC_LIMIT = ADDR_W'(PROG_LEN);
  localparam logic [ADDR_W-1:0] PC_INIT  = ADDR_W'(PC_RESET);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              inflight_q, inflight_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic [1:0]        count_q, count_d;
  logic [INST_W-1:0] e0_inst_q, e0_inst_d, e1_inst_q, e1_inst_d;
  logic [ADDR_W-1:0] e0_pc_q, e0_pc_d, e1_pc_q, e1_pc_d;
  logic              halted_q, halted_d;
  logic              fault_q, fault_d;

  logic              pop;
  logic              push;
  logic              issue;
  logic [2:0]        occ;

  assign o_mem_addr   = pc_q;
  assign o_inst       = e0_inst_q;
  assign o_inst_pc    = e0_pc_q;
  assign o_inst_valid = (count_q != 2'd0);
  assign o_halted     = halted_q;
  assign o_fault      = fault_q;

  // Next-state: issue decision, PC advance/redirect, and skid FIFO (entry 0 is the head)
  always_comb begin
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    count_d       = count_q;
    e0_inst_d     = e0_inst_q;
    e0_pc_d       = e0_pc_q;
    e1_inst_d     = e1_inst_q;
    e1_pc_d       = e1_pc_q;
    fault_d       = fault_q;

    pop   = (count_q != 2'd0) & i_inst_ready;
    push  = inflight_q & ~i_redirect;
    // Occupancy after this edge's pop, counting the return that lands now;
    // a new issue must leave room for its own return next cycle.
    occ   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue = ~i_redirect & ~i_halt & (occ < 3'd2);

    if (i_redirect) begin
      count_d = 2'd0;
      if (i_redirect_pc >= PC_LIMIT) begin
        pc_d    = '0;
        fault_d = 1'b1;
      end else begin
        pc_d = i_redirect_pc;
      end
    end else begin
      if (issue) begin
        inflight_d    = 1'b1;
        inflight_pc_d = pc_q;
        pc_d          = (pc_q == LAST_PC) ? '0 : pc_q + 1'b1;
      end

      if (push && pop) begin
        if (count_q == 2'd1) begin
          e0_inst_d = i_mem_data;
          e0_pc_d   = inflight_pc_q;
        end else begin
          e0_inst_d = e1_inst_q;
          e0_pc_d   = e1_pc_q;
          e1_inst_d = i_mem_data;
          e1_pc_d   = inflight_pc_q;
        end
      end else if (pop) begin
        e0_inst_d = e1_inst_q;
        e0_pc_d   = e1_pc_q;
        count_d   = count_q - 2'd1;
      end else if (push) begin
        if (count_q == 2'd0) begin
          e0_inst_d = i_mem_data;
          e0_pc_d   = inflight_pc_q;
        end else begin
          e1_inst_d = i_mem_data;
          e1_pc_d   = inflight_pc_q;
        end
        count_d = count_q + 2'd1;
      end
    end

    // Halted reflects the state the pipeline will be in after this edge.
    halted_d = i_halt & (count_d == 2'd0) & ~inflight_d;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= PC_INIT;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      count_q       <= 2'd0;
      e0_inst_q     <= '0;
      e0_pc_q       <= '0;
      e1_inst_q     <= '0;
      e1_pc_q       <= '0;
      halted_q      <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      count_q       <= count_d;
      e0_inst_q     <= e0_inst_d;
      e0_pc_q       <= e0_pc_d;
      e1_inst_q     <= e1_inst_d;
      e1_pc_q       <= e1_pc_d;
      halted_q      <= halted_d;
      fault_q       <= fault_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// tb/tb_inst_fetch_ctrl.sv - directed self-checking bench for inst_fetch_ctrl
module tb_inst_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] o_mem_addr;
  logic [15:0] i_mem_data;
  logic [15:0] o_inst;
  logic [31:0] o_inst_pc;
  logic        o_inst_valid;
  logic        i_inst_ready;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        i_halt;
  logic        o_halted;
  logic        o_fault;

  int checks   = 0;
  int failures = 0;

  logic [15:0] mem [0:3];

  inst_fetch_ctrl #(
    .ADDR_W(32), .INST_W(16), .PROG_LEN(4), .PC_RESET(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .o_mem_addr(o_mem_addr),
    .i_mem_data(i_mem_data),
    .o_inst(o_inst),
    .o_inst_pc(o_inst_pc),
    .o_inst_valid(o_inst_valid),
    .i_inst_ready(i_inst_ready),
    .i_redirect(i_redirect),
    .i_redirect_pc(i_redirect_pc),
    .i_halt(i_halt),
    .o_halted(o_halted),
    .o_fault(o_fault)
  );

  always #5 clk = ~clk;

  // Instruction memory with one-cycle registered read
  always @(posedge clk) i_mem_data <= mem[o_mem_addr[1:0]];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    mem[0] = 16'hA5C0;
    mem[1] = 16'h1234;
    mem[2] = 16'hBEEF;
    mem[3] = 16'h0F0F;
    rst = 1'b1; i_inst_ready = 1'b0; i_redirect = 1'b0; i_redirect_pc = '0; i_halt = 1'b0;
    step(); step();

    chk("rst_valid",  32'(o_inst_valid), 32'd0);
    chk("rst_inst",   32'(o_inst),       32'd0);
    chk("rst_instpc", o_inst_pc,         32'd0);
    chk("rst_halted", 32'(o_halted),     32'd0);
    chk("rst_fault",  32'(o_fault),      32'd0);
    chk("rst_addr",   o_mem_addr,        32'd0);

    // Streaming with ready high, including wrap
    rst = 1'b0; i_inst_ready = 1'b1;
    step();
    chk("t1_lat_valid", 32'(o_inst_valid), 32'd0);
    chk("t1_lat_addr",  o_mem_addr,        32'd1);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t1_valid", 32'(o_inst_valid), 32'd1);
      chk("t1_pc",    o_inst_pc,         32'(i % 4));
      chk("t1_inst",  32'(o_inst),       32'(mem[i % 4]));
    end

    // Reset while valid and stalled
    i_inst_ready = 1'b0;
    step();
    chk("t6_pre_valid", 32'(o_inst_valid), 32'd1);
    rst = 1'b1;
    step();
    chk("t6_valid",  32'(o_inst_valid), 32'd0);
    chk("t6_addr",   o_mem_addr,        32'd0);
    chk("t6_instpc", o_inst_pc,         32'd0);
    chk("t6_inst",   32'(o_inst),       32'd0);

    // Stall with ready low, then release
    rst = 1'b0;
    step();
    chk("t2_lat_valid", 32'(o_inst_valid), 32'd0);
    step();
    for (int k = 0; k < 5; k++) begin
      chk("t2_stall_valid", 32'(o_inst_valid), 32'd1);
      chk("t2_stall_pc",    o_inst_pc,         32'd0);
      chk("t2_stall_inst",  32'(o_inst),       32'(mem[0]));
      chk("t2_stall_addr",  o_mem_addr,        32'd2);
      if (k < 4) step();
    end
    i_inst_ready = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      step();
      chk("t2_valid", 32'(o_inst_valid), 32'd1);
      chk("t2_pc",    o_inst_pc,         32'(j % 4));
      chk("t2_inst",  32'(o_inst),       32'(mem[j % 4]));
    end

    // Redirect with pc0 buffered and pc1 in flight
    rst = 1'b1; i_inst_ready = 1'b0;
    step();
    rst = 1'b0;
    step(); step();
    chk("t3_pre_valid", 32'(o_inst_valid), 32'd1);
    chk("t3_pre_pc",    o_inst_pc,         32'd0);
    i_redirect = 1'b1; i_redirect_pc = 32'd2;
    step();
    chk("t3_n1_valid", 32'(o_inst_valid), 32'd0);
    chk("t3_n1_addr",  o_mem_addr,        32'd2);
    chk("t3_n1_fault", 32'(o_fault),      32'd0);
    i_redirect = 1'b0; i_inst_ready = 1'b1;
    step();
    chk("t3_n2_valid", 32'(o_inst_valid), 32'd0);
    step();
    chk("t3_n3_valid", 32'(o_inst_valid), 32'd1);
    chk("t3_n3_pc",    o_inst_pc,         32'd2);
    chk("t3_n3_inst",  32'(o_inst),       32'(mem[2]));
    step();
    chk("t3_n4_pc",    o_inst_pc,         32'd3);
    chk("t3_n4_addr",  o_mem_addr,        32'd1);

    // Halt mid-stream, drain, resume
    i_halt = 1'b1;
    step();
    chk("t4_drain_valid",  32'(o_inst_valid), 32'd1);
    chk("t4_drain_pc",     o_inst_pc,         32'd0);
    chk("t4_drain_halted", 32'(o_halted),     32'd0);
    chk("t4_drain_addr",   o_mem_addr,        32'd1);
    step();
    chk("t4_h_valid",  32'(o_inst_valid), 32'd0);
    chk("t4_h_halted", 32'(o_halted),     32'd1);
    chk("t4_h_addr",   o_mem_addr,        32'd1);
    step();
    chk("t4_h2_halted", 32'(o_halted), 32'd1);
    chk("t4_h2_addr",   o_mem_addr,    32'd1);
    i_halt = 1'b0;
    step();
    chk("t4_r_halted", 32'(o_halted),     32'd0);
    chk("t4_r_valid",  32'(o_inst_valid), 32'd0);
    chk("t4_r_addr",   o_mem_addr,        32'd2);
    step();
    chk("t4_r_pc1",   o_inst_pc,   32'd1);
    chk("t4_r_inst1", 32'(o_inst), 32'(mem[1]));
    step();
    chk("t4_r_pc2",   o_inst_pc,   32'd2);

    // Out-of-range redirect sets sticky fault and restarts at 0
    i_redirect = 1'b1; i_redirect_pc = 32'd7;
    step();
    chk("t5_fault",  32'(o_fault),      32'd1);
    chk("t5_valid",  32'(o_inst_valid), 32'd0);
    chk("t5_addr",   o_mem_addr,        32'd0);
    i_redirect = 1'b0;
    step();
    chk("t5_n2_valid", 32'(o_inst_valid), 32'd0);
    chk("t5_n2_fault", 32'(o_fault),      32'd1);
    step();
    chk("t5_n3_valid", 32'(o_inst_valid), 32'd1);
    chk("t5_n3_pc",    o_inst_pc,         32'd0);
    chk("t5_n3_inst",  32'(o_inst),       32'(mem[0]));
    step();
    chk("t5_n4_pc",    o_inst_pc,         32'd1);
    chk("t5_n4_fault", 32'(o_fault),      32'd1);
    rst = 1'b1;
    step();
    chk("t5_rst_fault", 32'(o_fault), 32'd0);
    rst = 1'b0;
    step(); step();
    chk("t5_post_valid", 32'(o_inst_valid), 32'd1);
    chk("t5_post_pc",    o_inst_pc,         32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
